// File: rtl/core_sequencer.sv
// core_sequencer
//   Generates the 17-bit instruction stream for one complete Q*K^T pass of the
//   attention core after a single start pulse: load Q rows, load K rows,
//   preload K into the PE array, execute, then drain the output FIFO into
//   psum memory. Host rows are forwarded on mem_out aligned with inst.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low; clears all state and outputs
//   start        begin a pass (honoured only in IDLE)
//   abort        synchronous return to IDLE from any state, no done pulse
//   in_valid     host row on mem_in is valid
//   mem_in       host Q/K row, pr*bw bits
//   ofifo_valid  core output FIFO holds a complete row
//   in_ready     combinational; high while Q or K rows are being accepted
//   mem_out      registered copy of the last accepted mem_in
//   inst         registered core instruction
//   busy         high whenever the sequencer is not idle
//   done         one-cycle pulse at the end of a completed pass
module core_sequencer #(
  parameter int col         = 8,
  parameter int pr          = 8,
  parameter int bw          = 4,
  parameter int total_cycle = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                in_valid,
  input  logic [pr*bw-1:0]    mem_in,
  input  logic                ofifo_valid,
  output logic                in_ready,
  output logic [pr*bw-1:0]    mem_out,
  output logic [16:0]         inst,
  output logic                busy,
  output logic                done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_QWR,
    S_KWR,
    S_KLD,
    S_KGAP,
    S_EXEC,
    S_DRAIN,
    S_PSUM,
    S_DONE
  } state_t;

  // Field layout of the core instruction word, msb first.
  typedef struct packed {
    logic       ofifo_rd;
    logic [3:0] qkmem_add;
    logic [3:0] pmem_add;
    logic       execute;
    logic       load;
    logic       qmem_rd;
    logic       qmem_wr;
    logic       kmem_rd;
    logic       kmem_wr;
    logic       pmem_rd;
    logic       pmem_wr;
  } inst_t;

  // Terminal counts: total_cycle and col are 1..16, so cnt never wraps.
  localparam logic [3:0] N_LAST = 4'(total_cycle - 1);
  localparam logic [3:0] C_LAST = 4'(col - 1);

  state_t     state;
  logic [3:0] cnt;
  inst_t      inst_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      inst_q  <= '0;
      mem_out <= '0;
      done    <= 1'b0;
    end else begin
      // NOTE: inst and done are pulse-style outputs, so they default to 0 every
      // cycle and only the active state sets bits; mem_out has no default
      // because it must hold the last accepted row.
      inst_q <= '0;
      done   <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state <= S_QWR;
              cnt   <= '0;
            end
          end
          S_QWR: begin
            if (in_valid) begin
              inst_q.qmem_wr   <= 1'b1;
              inst_q.qkmem_add <= cnt;
              mem_out          <= mem_in;
              if (cnt == N_LAST) begin
                state <= S_KWR;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end
          S_KWR: begin
            if (in_valid) begin
              inst_q.kmem_wr   <= 1'b1;
              inst_q.qkmem_add <= cnt;
              mem_out          <= mem_in;
              if (cnt == C_LAST) begin
                state <= S_KLD;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end
          S_KLD: begin
            inst_q.kmem_rd   <= 1'b1;
            inst_q.load      <= 1'b1;
            inst_q.qkmem_add <= cnt;
            if (cnt == C_LAST) begin
              state <= S_KGAP;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          S_KGAP: begin
            // One idle instruction lets the preloaded weights settle.
            state <= S_EXEC;
            cnt   <= '0;
          end
          S_EXEC: begin
            inst_q.qmem_rd   <= 1'b1;
            inst_q.execute   <= 1'b1;
            inst_q.qkmem_add <= cnt;
            if (cnt == N_LAST) begin
              state <= S_DRAIN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          S_DRAIN: begin
            if (ofifo_valid) begin
              state <= S_PSUM;
              cnt   <= '0;
            end
          end
          S_PSUM: begin
            if (ofifo_valid) begin
              inst_q.ofifo_rd <= 1'b1;
              inst_q.pmem_wr  <= 1'b1;
              inst_q.pmem_add <= cnt;
              if (cnt == N_LAST) begin
                state <= S_DONE;
                cnt   <= '0;
                // Raised on entry so the pulse coincides with the DONE state.
                done  <= 1'b1;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign inst     = inst_q;
  assign busy     = (state != S_IDLE);
  assign in_ready = reset & ((state == S_QWR) | (state == S_KWR));

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer. A transaction-level model (a queue
// of pass steps built from the instruction definitions) predicts every output
// each cycle; scenario code adds hand-computed literal expectations.
module tb_core_sequencer;

  localparam int COL = 8;
  localparam int PR  = 8;
  localparam int BW  = 4;
  localparam int TC  = 8;
  localparam int W   = PR * BW;
  localparam int BIG = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, abort, in_valid, ofifo_valid;
  logic [W-1:0] mem_in;
  logic         in_ready, busy, done;
  logic [W-1:0] mem_out;
  logic [16:0]  inst;

  logic         start_b, in_valid_b, ofifo_b;
  logic [W-1:0] mem_in_b;
  logic         in_ready_b, busy_b, done_b;
  logic [W-1:0] mem_out_b;
  logic [16:0]  inst_b;

  always #5 clk = ~clk;

  core_sequencer #(.col(COL), .pr(PR), .bw(BW), .total_cycle(TC)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_valid(in_valid), .mem_in(mem_in), .ofifo_valid(ofifo_valid),
    .in_ready(in_ready), .mem_out(mem_out), .inst(inst),
    .busy(busy), .done(done)
  );

  core_sequencer #(.col(BIG), .pr(PR), .bw(BW), .total_cycle(BIG)) dut_big (
    .clk(clk), .reset(reset), .start(start_b), .abort(1'b0),
    .in_valid(in_valid_b), .mem_in(mem_in_b), .ofifo_valid(ofifo_b),
    .in_ready(in_ready_b), .mem_out(mem_out_b), .inst(inst_b),
    .busy(busy_b), .done(done_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef enum int {K_BEAT, K_FIXED, K_WAIT, K_FBEAT, K_FIN} kind_e;
  typedef struct {
    kind_e       kind;
    logic [16:0] word;
  } step_t;

  step_t        q[$];
  bit           m_active;
  logic [16:0]  e_inst;
  logic [W-1:0] e_mem;
  bit           e_done, e_busy, e_ready;

  // A pass is an ordered script: beats wait for in_valid, fixed steps always
  // issue, the drain wait and psum beats wait for ofifo_valid.
  function automatic void build_pass();
    q.delete();
    for (int i = 0; i < TC; i++)  q.push_back('{K_BEAT,  17'((1 << 4) | (i << 12))});
    for (int i = 0; i < COL; i++) q.push_back('{K_BEAT,  17'((1 << 2) | (i << 12))});
    for (int i = 0; i < COL; i++) q.push_back('{K_FIXED, 17'((1 << 6) | (1 << 3) | (i << 12))});
    q.push_back('{K_FIXED, 17'd0});
    for (int i = 0; i < TC; i++)  q.push_back('{K_FIXED, 17'((1 << 7) | (1 << 5) | (i << 12))});
    q.push_back('{K_WAIT, 17'd0});
    for (int i = 0; i < TC; i++)  q.push_back('{K_FBEAT, 17'((1 << 16) | (1 << 0) | (i << 8))});
    q.push_back('{K_FIN, 17'd0});
  endfunction

  function automatic void model_reset();
    q.delete();
    m_active = 1'b0;
    e_inst   = '0;
    e_mem    = '0;
    e_done   = 1'b0;
    e_busy   = 1'b0;
    e_ready  = 1'b0;
  endfunction

  function automatic void model_step(input bit st, input bit ab, input bit iv,
                                     input bit ov, input logic [W-1:0] mi);
    e_inst = '0;
    e_done = 1'b0;
    if (ab) begin
      q.delete();
      m_active = 1'b0;
    end else if (!m_active) begin
      if (st) begin
        build_pass();
        m_active = 1'b1;
      end
    end else begin
      case (q[0].kind)
        K_BEAT:  if (iv) begin e_inst = q[0].word; e_mem = mi; void'(q.pop_front()); end
        K_FIXED: begin e_inst = q[0].word; void'(q.pop_front()); end
        K_WAIT:  if (ov) void'(q.pop_front());
        K_FBEAT: if (ov) begin e_inst = q[0].word; void'(q.pop_front()); end
        default: begin void'(q.pop_front()); m_active = 1'b0; end
      endcase
      if (q.size() > 0 && q[0].kind == K_FIN) e_done = 1'b1;
    end
    e_busy  = m_active;
    e_ready = m_active && q.size() > 0 && q[0].kind == K_BEAT;
  endfunction

  int rst_count = 0;
  int rst_seen  = 0;
  bit cmp_en    = 1'b0;

  always @(negedge reset) rst_count++;

  // Compare process: advance the model at each rising edge, check at the
  // following falling edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!reset) begin
        model_reset();
        rst_seen = rst_count;
      end else begin
        if (rst_seen != rst_count) begin
          model_reset();
          rst_seen = rst_count;
        end
        model_step(start, abort, in_valid, ofifo_valid, mem_in);
      end
      @(negedge clk);
      if (cmp_en && reset) begin
        check("m_inst", 32'(inst), 32'(e_inst));
        check("m_mem_out", mem_out, e_mem);
        check("m_done", 32'(done), 32'(e_done));
        check("m_busy", 32'(busy), 32'(e_busy));
        check("m_in_ready", 32'(in_ready), 32'(e_ready));
      end
    end
  end

  // ---------------- scenarios ----------------
  // iv_mode/of_mode: 0 always valid, 1 toggling 1,0,..., 2 random.
  task automatic run_pass(input int iv_mode, input int of_mode,
                          input bit extra_starts, input string tag);
    int k = 0, nq = 0, nk = 0, nl = 0, ne = 0, np = 0, ndone = 0, done_at = -1;
    bit finished = 1'b0;
    bit nominal;
    nominal = (iv_mode == 0) && (of_mode == 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 600 && !finished; c++) begin
      bit beat;
      case (iv_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = c[0];
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      case (of_mode)
        0:       ofifo_valid = 1'b1;
        1:       ofifo_valid = c[0];
        default: ofifo_valid = 1'($urandom_range(0, 1));
      endcase
      mem_in = (iv_mode == 0) ? {PR{k[3:0]}} : W'($urandom);
      start  = extra_starts && (c == 3 || done);
      beat   = in_ready && in_valid;
      tick();
      if (beat) k++;
      if (inst[4]) begin check({tag, "_qaddr"}, 32'(inst[15:12]), nq); nq++; end
      if (inst[2]) begin check({tag, "_kaddr"}, 32'(inst[15:12]), nk); nk++; end
      if (inst[6]) begin check({tag, "_laddr"}, 32'(inst[15:12]), nl); nl++; end
      if (inst[7]) begin check({tag, "_eaddr"}, 32'(inst[15:12]), ne); ne++; end
      if (inst[0]) begin check({tag, "_paddr"}, 32'(inst[11:8]), np); np++; end
      if (nominal) begin
        case (c)
          1:  begin check({tag, "_c1_inst"}, 32'(inst), 32'h00010); check({tag, "_c1_mem"}, mem_out, 32'h00000000); end
          8:  check({tag, "_c8_mem"}, mem_out, 32'h77777777);
          9:  begin check({tag, "_c9_inst"}, 32'(inst), 32'h00004); check({tag, "_c9_mem"}, mem_out, 32'h88888888); end
          16: check({tag, "_c16_mem"}, mem_out, 32'hFFFFFFFF);
          24: check({tag, "_c24_inst"}, 32'(inst), 32'h07048);
          25: check({tag, "_c25_inst"}, 32'(inst), 32'h00000);
          26: check({tag, "_c26_inst"}, 32'(inst), 32'h000A0);
          35: check({tag, "_c35_inst"}, 32'(inst), 32'h10001);
          42: check({tag, "_c42_inst"}, 32'(inst), 32'h10701);
          default: ;
        endcase
      end
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (done_at >= 0 && !busy) finished = 1'b1;
    end
    start = 1'b0;
    check({tag, "_finished"}, 32'(finished), 1);
    check({tag, "_nq"}, nq, TC);
    check({tag, "_nk"}, nk, COL);
    check({tag, "_nl"}, nl, COL);
    check({tag, "_ne"}, ne, TC);
    check({tag, "_np"}, np, TC);
    check({tag, "_ndone"}, ndone, 1);
    if (nominal) check({tag, "_done_cycle"}, done_at, 42);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    int nd;
    int bq, bk, bl, be, bp, bdone_at, bmax_qk, bmax_p;

    reset = 1'b0;
    start = 1'b0; abort = 1'b0; in_valid = 1'b0; ofifo_valid = 1'b0; mem_in = '0;
    start_b = 1'b0; in_valid_b = 1'b1; ofifo_b = 1'b1; mem_in_b = '0;
    repeat (3) tick();
    check("rst_inst", 32'(inst), 0);
    check("rst_mem_out", mem_out, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    reset = 1'b1;
    tick();
    cmp_en = 1'b1;

    // Nominal pass with rows 0x...0 .. 0x...F.
    run_pass(0, 0, 1'b0, "nom");
    repeat (2) tick();

    // Stalls on both handshakes.
    run_pass(1, 1, 1'b0, "stall");
    repeat (2) tick();

    // start during QWR and during DONE must be ignored.
    run_pass(0, 0, 1'b1, "xstart");
    repeat (3) tick();
    check("xstart_idle_after", 32'(busy), 0);

    // abort together with start in IDLE stays idle.
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_start_idle", 32'(busy), 0);
    tick();
    check("abort_start_idle2", 32'(busy), 0);

    // Abort at EXEC with cnt=3: last issued execute was address 2.
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; ofifo_valid = 1'b1; mem_in = W'($urandom);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      tick();
      if (inst[7] && inst[15:12] == 4'd2) hit = 1'b1;
    end
    check("abort_reach_exec", 32'(hit), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_inst", 32'(inst), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    nd = 0;
    repeat (50) begin
      tick();
      if (done) nd++;
    end
    check("abort_no_done", nd, 0);
    run_pass(0, 0, 1'b0, "replay");
    repeat (2) tick();

    // Asynchronous reset pulse in the middle of KLD.
    mem_in = 32'hA5A5A5A5;
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; ofifo_valid = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      tick();
      if (inst[6] && inst[15:12] == 4'd3) hit = 1'b1;
    end
    check("areset_reach_kld", 32'(hit), 1);
    check("areset_mem_before", mem_out, 32'hA5A5A5A5);
    #1 reset = 1'b0;
    #1;
    check("areset_inst", 32'(inst), 0);
    check("areset_mem_out", mem_out, 0);
    check("areset_busy", 32'(busy), 0);
    check("areset_in_ready", 32'(in_ready), 0);
    check("areset_done", 32'(done), 0);
    #2 reset = 1'b1;
    in_valid = 1'b0;
    tick();
    check("areset_idle_busy", 32'(busy), 0);
    check("areset_idle_inst", 32'(inst), 0);
    tick();

    // Random handshake passes.
    repeat (3) begin
      run_pass(2, 2, 1'b0, "rand");
      repeat (2) tick();
    end

    // 16x16 build: addresses must reach 15 without wrap.
    bq = 0; bk = 0; bl = 0; be = 0; bp = 0; bdone_at = -1; bmax_qk = 0; bmax_p = 0;
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int c = 1; c <= 300 && bdone_at < 0; c++) begin
      mem_in_b = W'($urandom);
      tick();
      if (inst_b[4]) begin check("big_qaddr", 32'(inst_b[15:12]), bq); bq++; end
      if (inst_b[2]) begin check("big_kaddr", 32'(inst_b[15:12]), bk); bk++; end
      if (inst_b[6]) begin check("big_laddr", 32'(inst_b[15:12]), bl); bl++; end
      if (inst_b[7]) begin check("big_eaddr", 32'(inst_b[15:12]), be); be++; end
      if (inst_b[0]) begin check("big_paddr", 32'(inst_b[11:8]), bp); bp++; end
      if (32'(inst_b[15:12]) > bmax_qk) bmax_qk = 32'(inst_b[15:12]);
      if (32'(inst_b[11:8]) > bmax_p) bmax_p = 32'(inst_b[11:8]);
      if (done_b) bdone_at = c;
    end
    check("big_nq", bq, BIG);
    check("big_nk", bk, BIG);
    check("big_nl", bl, BIG);
    check("big_ne", be, BIG);
    check("big_np", bp, BIG);
    check("big_max_qk", bmax_qk, 15);
    check("big_max_p", bmax_p, 15);
    check("big_done_cycle", bdone_at, 82);
    tick();
    check("big_idle_after", 32'(busy_b), 0);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
